// File: rtl/memory_bus_responder_pkg.sv
// memory_bus_responder_pkg: FSM encoding, region indices and timeout default for the bus responder
package memory_bus_responder_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  localparam int BRAM = 0;
  localparam int SRAM = 1;
  localparam int FLASH = 2;
  localparam int PERIPH = 3;
  localparam int TIMEOUT_DEFAULT = 16;
  function automatic logic [3:0] lowest_sel(input logic [3:0] sel);
    return sel & (~sel + 4'd1);
  endfunction
endpackage

// File: rtl/memory_bus_responder_timeout.sv
// bus_timeout_counter: counts enabled cycles from zero, flags the last allowed one
module bus_timeout_counter
  import memory_bus_responder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (enable) count <= count + W'(1);
  assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: routes one master transfer to a selected slave with timeout and unmapped-error handling
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ready,
  output logic [31:0] m_rdata,
  output logic        m_err,
  input  logic [3:0]  region_sel,
  output logic [3:0]  s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [3:0]  s_ack,
  input  logic [31:0] s_rdata0,
  input  logic [31:0] s_rdata1,
  input  logic [31:0] s_rdata2,
  input  logic [31:0] s_rdata3
);
  state_t state, state_n;
  logic [3:0] sel_r, sel_n;
  logic hit, expired, accept;
  logic [31:0] rd;
  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(state != ACCESS),
    .enable(state == ACCESS),
    .expired(expired)
  );
  assign sel_n = lowest_sel(region_sel);
  assign accept = state == IDLE && m_req;
  assign hit = state == ACCESS && |(s_ack & sel_r);
  assign rd = sel_r[BRAM] ? s_rdata0 : sel_r[SRAM] ? s_rdata1 : sel_r[FLASH] ? s_rdata2 : s_rdata3;
  // an ack on the timeout cycle still wins over the error
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = m_req ? (|sel_n ? ACCESS : ERR) : IDLE;
      ACCESS:  state_n = hit ? RESP : expired ? ERR : ACCESS;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_r   <= '0;
      s_req   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      state   <= state_n;
      if (accept) begin
        sel_r   <= sel_n;
        s_we    <= m_we;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
      end
      s_req   <= state_n == ACCESS ? (accept ? sel_n : sel_r) : '0;
      m_ready <= state_n == RESP || state_n == ERR;
      m_err   <= state_n == ERR;
      m_rdata <= hit && !s_we ? rd : '0;
    end
  end
endmodule
